wb_stage: RTL

- Final (write-back) pipeline stage. Consumes the memory stage's result bus and commits it to the register file.
- Owns the CP0 register set: Status, Cause, EPC, Count, Compare, BadVAddr.
- Detects exceptions, interrupts and eret at commit, then drives the pipeline-wide flush and redirect target.
- Also drives the WB forwarding path and the debug trace port.

---
 rtl/wb_stage_pkg.sv | 91 +++++++++
 rtl/wb_stage_cp0.sv | 158 +++++++++++++++
 rtl/wb_stage.sv | 118 +++++++++++
 3 files changed

// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: bus layout, exception
// codes, CP0 register selects and reset constants.
package wb_stage_pkg;

    localparam int          MS_WS_BUS_WD = 121;
    localparam logic [31:0] EX_ENTRY_DEF = 32'hBFC0_0380;

    // Bit offsets of the memory-to-WB bus fields
    localparam int RT_LSB   = 89;
    localparam int BD_BIT   = 88;
    localparam int EXT_LSB  = 85;
    localparam int ERET_BIT = 84;
    localparam int RDS_LSB  = 76;
    localparam int SEL_LSB  = 73;
    localparam int MTC0_BIT = 72;
    localparam int MFC0_BIT = 71;
    localparam int DV_BIT   = 70;
    localparam int GRWE_BIT = 69;
    localparam int DEST_LSB = 64;
    localparam int RES_LSB  = 32;
    localparam int PC_LSB   = 0;

    typedef enum logic [2:0] {
        EXT_NONE = 3'd0,
        EXT_SYS  = 3'd1,
        EXT_BRK  = 3'd2,
        EXT_RI   = 3'd3,
        EXT_OV   = 3'd4,
        EXT_ADEL = 3'd5,
        EXT_ADES = 3'd6,
        EXT_RSV  = 3'd7
    } ex_type_e;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    typedef enum logic [2:0] {
        SEL_STATUS  = 3'd0,
        SEL_CAUSE   = 3'd1,
        SEL_EPC     = 3'd2,
        SEL_COUNT   = 3'd3,
        SEL_COMPARE = 3'd4,
        SEL_BADV    = 3'd5,
        SEL_RSV6    = 3'd6,
        SEL_RSV7    = 3'd7
    } cp0_sel_e;

    localparam logic [31:0] STATUS_RST = 32'h0040_0000;

    // Field order matches the offsets above, MSB first
    typedef struct packed {
        logic [31:0] rt_value;
        logic        bd;
        logic [2:0]  ex_type;
        logic        eret;
        logic [7:0]  rd_sel;
        logic [2:0]  cp0_choose;
        logic        mtc0;
        logic        mfc0;
        logic        dest_valid;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_ws_bus_t;

    function automatic logic is_exc(logic [2:0] t);
        return (t != EXT_NONE) && (t != EXT_RSV);
    endfunction

    function automatic logic [4:0] exc_code(logic [2:0] t);
        logic [4:0] c;
        c = EXC_INT;
        case (t)
            EXT_SYS:  c = EXC_SYS;
            EXT_BRK:  c = EXC_BP;
            EXT_RI:   c = EXC_RI;
            EXT_OV:   c = EXC_OV;
            EXT_ADEL: c = EXC_ADEL;
            EXT_ADES: c = EXC_ADES;
            default:  c = EXC_INT;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/wb_stage_cp0.sv
// CP0 register file: Status, Cause, EPC, Count, Compare, BadVAddr,
// plus the timer and interrupt-pending logic.
// Ports: clk_i/reset_i; ext_int_i hardware lines; wen_i/waddr_i/wdata_i
// mtc0 write; exc_i/exc_code_i/bd_i/pc_i/badv_we_i/badv_i exception
// commit; eret_i; raddr_i/rdata_o mfc0 read; epc_o; int_req_o.
module cp0_regs
    import wb_stage_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [5:0]  ext_int_i,
    input  logic        wen_i,
    input  logic [2:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic        exc_i,
    input  logic [4:0]  exc_code_i,
    input  logic        bd_i,
    input  logic [31:0] pc_i,
    input  logic        badv_we_i,
    input  logic [31:0] badv_i,
    input  logic        eret_i,
    input  logic [2:0]  raddr_i,
    output logic [31:0] rdata_o,
    output logic [31:0] epc_o,
    output logic        int_req_o
);

    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic        ti_q, ti_d;
    logic [5:0]  ip_hw_q, ip_hw_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [4:0]  code_q, code_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic [31:0] badv_q, badv_d;
    logic        tick_q, tick_d;

    logic [31:0] status_w;
    logic [31:0] cause_w;

    assign status_w = STATUS_RST | {16'h0, im_q, 6'h0, exl_q, ie_q};
    assign cause_w  = {bd_q, ti_q, 14'h0, ip_hw_q, ip_sw_q,
                       1'b0, code_q, 2'b00};

    always_comb begin
        im_d      = im_q;
        exl_d     = exl_q;
        ie_d      = ie_q;
        bd_d      = bd_q;
        ti_d      = ti_q;
        ip_sw_d   = ip_sw_q;
        code_d    = code_q;
        epc_d     = epc_q;
        compare_d = compare_q;
        badv_d    = badv_q;
        // Count advances on every other cycle
        tick_d    = ~tick_q;
        count_d   = tick_q ? count_q + 32'd1 : count_q;
        // Hardware IP bits track the lines each cycle; IP7 also carries TI
        ip_hw_d   = {ext_int_i[5] | ti_q, ext_int_i[4:0]};

        if (count_q == compare_q) begin
            ti_d = 1'b1;
        end

        // Software writes take priority over timer match and count tick
        if (wen_i) begin
            case (waddr_i)
                SEL_STATUS: begin
                    im_d  = wdata_i[15:8];
                    exl_d = wdata_i[1];
                    ie_d  = wdata_i[0];
                end
                SEL_CAUSE:   ip_sw_d = wdata_i[9:8];
                SEL_EPC:     epc_d   = wdata_i;
                SEL_COUNT: begin
                    count_d = wdata_i;
                    tick_d  = 1'b0;
                end
                SEL_COMPARE: begin
                    compare_d = wdata_i;
                    ti_d      = 1'b0;
                end
                SEL_BADV:    badv_d  = wdata_i;
                default: ;
            endcase
        end

        if (exc_i) begin
            exl_d  = 1'b1;
            code_d = exc_code_i;
            // A nested exception keeps the original return point
            if (!exl_q) begin
                bd_d  = bd_i;
                epc_d = bd_i ? pc_i - 32'd4 : pc_i;
            end
            if (badv_we_i) begin
                badv_d = badv_i;
            end
        end else if (eret_i) begin
            exl_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            im_q      <= 8'h0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            bd_q      <= 1'b0;
            ti_q      <= 1'b0;
            ip_hw_q   <= 6'h0;
            ip_sw_q   <= 2'h0;
            code_q    <= 5'h0;
            epc_q     <= 32'h0;
            count_q   <= 32'h0;
            compare_q <= 32'h0;
            badv_q    <= 32'h0;
            tick_q    <= 1'b0;
        end else begin
            im_q      <= im_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            bd_q      <= bd_d;
            ti_q      <= ti_d;
            ip_hw_q   <= ip_hw_d;
            ip_sw_q   <= ip_sw_d;
            code_q    <= code_d;
            epc_q     <= epc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            badv_q    <= badv_d;
            tick_q    <= tick_d;
        end
    end

    always_comb begin
        rdata_o = 32'h0;
        case (raddr_i)
            SEL_STATUS:  rdata_o = status_w;
            SEL_CAUSE:   rdata_o = cause_w;
            SEL_EPC:     rdata_o = epc_q;
            SEL_COUNT:   rdata_o = count_q;
            SEL_COMPARE: rdata_o = compare_q;
            SEL_BADV:    rdata_o = badv_q;
            default:     rdata_o = 32'h0;
        endcase
    end

    assign epc_o     = epc_q;
    assign int_req_o = ie_q && !exl_q
                    && |({ip_hw_q, ip_sw_q} & im_q);

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: commits the memory-stage result to the register
// file, resolves exceptions/interrupts/eret and drives flush+redirect.
// Ports: clk/reset; ms_to_ws_valid/ms_to_ws_bus/ws_allowin handshake;
// ext_int_in; rf_we/rf_waddr/rf_wdata; ws_to_ds_fw forwarding;
// ex_flush/ex_target redirect; debug_wb_* trace.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter logic [31:0] EX_ENTRY = EX_ENTRY_DEF,
    parameter int          BUS_WD   = MS_WS_BUS_WD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ms_to_ws_valid,
    input  logic [BUS_WD-1:0] ms_to_ws_bus,
    output logic              ws_allowin,
    input  logic [5:0]        ext_int_in,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [31:0]       rf_wdata,
    output logic [38:0]       ws_to_ds_fw,
    output logic              ex_flush,
    output logic [31:0]       ex_target,
    output logic [31:0]       debug_wb_pc,
    output logic [3:0]        debug_wb_rf_wen,
    output logic [4:0]        debug_wb_rf_wnum,
    output logic [31:0]       debug_wb_rf_wdata
);

    logic              ws_valid_q, ws_valid_d;
    logic [BUS_WD-1:0] ws_bus_q, ws_bus_d;
    logic              ws_ready_go;
    ms_ws_bus_t        b;

    logic        int_req;
    logic        ws_exc;
    logic        cp0_wen;
    logic        cp0_eret;
    logic        badv_we;
    logic [4:0]  code;
    logic [31:0] cp0_rdata;
    logic [31:0] epc;
    logic        fw_valid;
    logic [7:0]  unused_rd_sel;

    assign b             = ms_ws_bus_t'(ws_bus_q);
    assign unused_rd_sel = b.rd_sel;

    assign ws_ready_go = 1'b1;
    assign ws_allowin  = !ws_valid_q || ws_ready_go;

    always_comb begin
        ws_valid_d = ws_valid_q;
        ws_bus_d   = ws_bus_q;
        if (ex_flush) begin
            ws_valid_d = 1'b0;
        end else if (ws_allowin) begin
            ws_valid_d = ms_to_ws_valid;
        end
        if (ms_to_ws_valid && ws_allowin) begin
            ws_bus_d = ms_to_ws_bus;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid_q <= 1'b0;
            ws_bus_q   <= '0;
        end else begin
            ws_valid_q <= ws_valid_d;
            ws_bus_q   <= ws_bus_d;
        end
    end

    // An interrupt outranks whatever exception the instruction carries
    assign ws_exc   = ws_valid_q && (int_req || is_exc(b.ex_type));
    assign code     = int_req ? EXC_INT : exc_code(b.ex_type);
    assign badv_we  = !int_req
                   && (b.ex_type == EXT_ADEL || b.ex_type == EXT_ADES);
    assign cp0_wen  = ws_valid_q && b.mtc0 && !ws_exc;
    assign cp0_eret = ws_valid_q && b.eret && !ws_exc;

    cp0_regs u_cp0 (
        .clk_i      (clk),
        .reset_i    (reset),
        .ext_int_i  (ext_int_in),
        .wen_i      (cp0_wen),
        .waddr_i    (b.cp0_choose),
        .wdata_i    (b.rt_value),
        .exc_i      (ws_exc),
        .exc_code_i (code),
        .bd_i       (b.bd),
        .pc_i       (b.pc),
        .badv_we_i  (badv_we),
        .badv_i     (b.final_result),
        .eret_i     (cp0_eret),
        .raddr_i    (b.cp0_choose),
        .rdata_o    (cp0_rdata),
        .epc_o      (epc),
        .int_req_o  (int_req)
    );

    assign ex_flush  = ws_exc || (ws_valid_q && b.eret);
    assign ex_target = ws_exc ? EX_ENTRY : epc;

    assign rf_we    = ws_valid_q && b.gr_we && !ws_exc;
    assign rf_waddr = b.dest;
    assign rf_wdata = b.mfc0 ? cp0_rdata : b.final_result;
    assign fw_valid = ws_valid_q && b.dest_valid && !ws_exc;

    assign ws_to_ds_fw = {1'b0, fw_valid, b.dest, rf_wdata};

    assign debug_wb_pc       = b.pc;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

endmodule
